// File: rtl/load_arb_pkg.sv
// Shared sizing for the load arbiter: default data width, index-width helper and
// the supported requester/register counts.
package load_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREQ_MAX   = 8;
  localparam int NREG_MAX   = 16;

  // Index width for n items; a single-entry space still needs one bit.
  function automatic int aw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0, take the
// lowest set bit, then rotate the grant back to requester numbering.
module rr_pick
  import load_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = aw_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [2*N-1:0] req_dbl, gnt_dbl;
  logic [N-1:0]   rot, rot_gnt;
  logic [PW-1:0]  rot_idx;
  logic [PW:0]    idx_sum;

  assign req_dbl = {req, req} >> ptr;
  assign rot     = req_dbl[N-1:0];

  // Scan downward so the lowest rotated index is the last one written.
  always_comb begin
    rot_gnt = '0;
    rot_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_gnt    = '0;
        rot_gnt[i] = 1'b1;
        rot_idx    = PW'(i);
      end
    end
  end

  assign gnt_dbl    = {rot_gnt, rot_gnt} << ptr;
  assign gnt_onehot = gnt_dbl[2*N-1:N];
  assign idx_sum    = {1'b0, rot_idx} + {1'b0, ptr};
  assign gnt_idx    = (idx_sum >= (PW+1)'(N)) ? PW'(idx_sum - (PW+1)'(N)) : PW'(idx_sum);
  assign any        = |req;

endmodule

// File: rtl/load_arbiter.sv
// Round-robin arbiter handing one requester per cycle onto a shared load_reg bank:
// registered ack / one-hot load strobe / value, plus a registered busy flag.
module load_arbiter
  import load_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NREG   = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = aw_of(NREG),
  parameter int PW     = aw_of(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic                   hold,
  output logic [NREQ-1:0]        ack,
  output logic [NREG-1:0]        load,
  output logic [DATA_W-1:0]      value,
  output logic                   busy
);

  logic [PW-1:0]     ptr, ptr_nxt, gnt_idx;
  logic [NREQ-1:0]   eligible, gnt_onehot;
  logic              any, grant;
  logic [DATA_W-1:0] sel_data;
  logic [AW-1:0]     sel_addr;
  logic [NREG-1:0]   dec;

  // A requester being acked this cycle may still hold req high; that is a new
  // item and must wait at least one cycle.
  assign eligible = req & ~ack;
  assign grant    = any & ~hold;
  assign ptr_nxt  = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req        (eligible),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_onehot[i]) begin
        sel_data |= req_data[i*DATA_W +: DATA_W];
        sel_addr |= req_addr[i*AW +: AW];
      end
    end
  end

  // Out-of-range addresses match no register, so the strobe is silently dropped.
  always_comb begin
    dec = '0;
    for (int r = 0; r < NREG; r++) dec[r] = (sel_addr == AW'(r));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack   <= '0;
      load  <= '0;
      value <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
    end else begin
      busy <= |(req & ~ack);
      if (grant) begin
        ack   <= gnt_onehot;
        load  <= dec;
        value <= sel_data;
        ptr   <= ptr_nxt;
      end else begin
        ack  <= '0;
        load <= '0;
      end
    end
  end

endmodule

// File: tb/tb_load_arbiter.sv
// Directed and randomized checks of load_arbiter against a round-robin reference
// model built from the arbitration rules.
module tb_load_arbiter;
  localparam int NREQ = 4;
  localparam int NREG = 5;
  localparam int DW   = 8;
  localparam int AW   = 3;

  logic                 clk, rst_n, hold;
  logic [NREQ-1:0]      req;
  logic [DW-1:0]        d [NREQ];
  logic [AW-1:0]        a [NREQ];
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ-1:0]      ack;
  logic [NREG-1:0]      load;
  logic [DW-1:0]        value;
  logic                 busy;

  assign req_data = {d[3], d[2], d[1], d[0]};
  assign req_addr = {a[3], a[2], a[1], a[0]};

  load_arbiter #(.NREQ(NREQ), .NREG(NREG), .DATA_W(DW)) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_data(req_data), .req_addr(req_addr),
    .hold(hold), .ack(ack), .load(load), .value(value), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_ack, m_ptr;
  logic [NREG-1:0] m_load;
  logic [DW-1:0]   m_value;
  logic            m_busy;
  logic [NREQ-1:0] prev_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: winner is the first requester at or after ptr (mod NREQ) that is
  // requesting and was not acked in the current cycle.
  task automatic model_step();
    int w, idx;
    logic bn;
    if (!rst_n) begin
      m_ack = -1; m_load = '0; m_value = '0; m_busy = 1'b0; m_ptr = 0;
    end else begin
      bn = 1'b0;
      for (int i = 0; i < NREQ; i++) if (req[i] && m_ack != i) bn = 1'b1;
      w = -1;
      if (!hold) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && req[idx] && idx != m_ack) w = idx;
        end
      end
      m_busy = bn;
      if (w >= 0) begin
        m_ack   = w;
        m_value = d[w];
        m_load  = (int'(a[w]) < NREG) ? NREG'(1) << a[w] : '0;
        m_ptr   = (w + 1) % NREQ;
      end else begin
        m_ack  = -1;
        m_load = '0;
      end
    end
  endtask

  task automatic model_check();
    logic [NREQ-1:0] ea;
    ea = (m_ack < 0) ? '0 : NREQ'(1) << m_ack;
    chk("model_ack", 32'(ack), 32'(ea));
    chk("model_load", 32'(load), 32'(m_load));
    chk("model_value", 32'(value), 32'(m_value));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("no_adjacent_ack", 32'(|(ack & prev_ack)), 32'd0);
    prev_ack = ack;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; req = '0; prev_ack = '0;
    for (int i = 0; i < NREQ; i++) begin d[i] = '0; a[i] = '0; end
    m_ack = -1; m_ptr = 0; m_load = '0; m_value = '0; m_busy = 1'b0;
    tick(); tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // single request
    rst_n = 1'b1; req = 4'b0001; d[0] = 8'hA5; a[0] = 3'd2;
    tick();
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_load", 32'(load), 32'h04);
    chk("single_value", 32'(value), 32'hA5);
    req = '0;
    tick();
    chk("single_idle_load", 32'(load), 32'h0);

    // all four held from reset
    rst_n = 1'b0; req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin d[i] = 8'h10 + 8'(i); a[i] = 3'(i); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_order_ack", 32'(ack), 32'(1) << (k % NREQ));
      chk("rr_order_value", 32'(value), 32'h10 + 32'(k % NREQ));
    end
    req = '0; tick();

    // wrap: winner 2 leaves ptr=3, then {2,0} requesting -> 0
    req = 4'b0100; tick();
    chk("wrap_first", 32'(ack), 32'h4);
    req = '0; tick();
    req = 4'b0101; tick();
    chk("wrap_second", 32'(ack), 32'h1);
    req = '0; tick();

    // hold
    req = 4'b0010; hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_ack", 32'(ack), 32'h0);
      chk("hold_load", 32'(load), 32'h0);
    end
    hold = 1'b0; tick();
    chk("hold_release_ack", 32'(ack), 32'h2);
    req = '0; tick();

    // out-of-range address
    req = 4'b0001; a[0] = 3'd5; d[0] = 8'h3C; tick();
    chk("oor_ack", 32'(ack), 32'h1);
    chk("oor_load", 32'(load), 32'h0);
    chk("oor_value", 32'(value), 32'h3C);
    req = '0; tick();

    // reset during the grant cycle, then fresh priority from requester 0
    req = 4'b0100; rst_n = 1'b0; tick();
    chk("rst_mid_ack", 32'(ack), 32'h0);
    chk("rst_mid_load", 32'(load), 32'h0);
    rst_n = 1'b1; req = 4'b1001; tick();
    chk("rst_fresh_ack", 32'(ack), 32'h1);
    req = '0; tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      req   = NREQ'($urandom_range(0, 15));
      hold  = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < NREQ; i++) begin
        d[i] = DW'($urandom);
        a[i] = AW'($urandom_range(0, 7));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
